// File: rtl/counter_bank_if.sv
// counter_bank_if: word-wide access port of the counter bank.
//   wr_en/wr_addr/wr_hi/wr_data : preload one half of one counter
//   rd_en/rd_addr/rd_hi         : read request (lo captures hi into a shadow)
//   rd_data/rd_valid            : registered read response, 1-cycle latency
// master drives requests and consumes responses; slave is the counter bank.
interface counter_bank_if #(
  parameter int unsigned BUS_WIDTH = 32,
  parameter int unsigned AW        = 2
);
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic                 wr_hi;
  logic [BUS_WIDTH-1:0] wr_data;
  logic                 rd_en;
  logic [AW-1:0]        rd_addr;
  logic                 rd_hi;
  logic [BUS_WIDTH-1:0] rd_data;
  logic                 rd_valid;

  modport master (
    output wr_en, wr_addr, wr_hi, wr_data, rd_en, rd_addr, rd_hi,
    input  rd_data, rd_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_hi, wr_data, rd_en, rd_addr, rd_hi,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/counter_bank.sv
// counter_bank: CHANNELS independent WIDTH-bit up-counters behind a
// BUS_WIDTH-wide access port, with per-channel sticky overflow flags.
//   clk     : clock, all state updates on the rising edge
//   reset   : synchronous active-high reset, loads PRESET everywhere
//   inc     : per-channel increment request
//   inhibit : per-channel count gate (1 = inc ignored)
//   ovf     : per-channel sticky overflow flag (registered)
//   bus     : counter_bank_if.slave word access port (registered responses)
// A lo read snapshots the hi half into a shadow register so a following hi
// read returns a coherent WIDTH-bit value even if a carry happens between.
module counter_bank #(
  parameter int unsigned     WIDTH     = 64,
  parameter int unsigned     CHANNELS  = 4,
  parameter int unsigned     BUS_WIDTH = 32,
  parameter bit              SATURATE  = 1'b0,
  parameter logic [WIDTH-1:0] PRESET   = '0,
  parameter int unsigned     AW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] inc,
  input  logic [CHANNELS-1:0] inhibit,
  output logic [CHANNELS-1:0] ovf,
  counter_bank_if.slave       bus
);

  // Width of the upper half held in the shadow register.
  localparam int unsigned HW = WIDTH - BUS_WIDTH;

  logic [WIDTH-1:0]     cnt_q [CHANNELS];
  logic [WIDTH-1:0]     cnt_d [CHANNELS];
  logic [CHANNELS-1:0]  ovf_q, ovf_d;
  logic [HW-1:0]        shadow_q, shadow_d;
  logic [BUS_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                 rd_valid_q;

  logic [BUS_WIDTH-1:0] rd_lo_c;
  logic [HW-1:0]        rd_hi_c;

  // Counter and overflow next state; a write to a channel beats its increment.
  always_comb begin
    for (int i = 0; i < int'(CHANNELS); i++) begin
      cnt_d[i] = cnt_q[i];
      ovf_d[i] = ovf_q[i];
      if (bus.wr_en && (bus.wr_addr == AW'(i))) begin
        if (bus.wr_hi) begin
          cnt_d[i][WIDTH-1:BUS_WIDTH] = bus.wr_data[HW-1:0];
        end else begin
          cnt_d[i][BUS_WIDTH-1:0] = bus.wr_data;
        end
        ovf_d[i] = 1'b0;
      end else if (inc[i] && !inhibit[i]) begin
        if (&cnt_q[i]) begin
          ovf_d[i] = 1'b1;
          cnt_d[i] = SATURATE ? cnt_q[i] : '0;
        end else begin
          cnt_d[i] = cnt_q[i] + WIDTH'(1);
        end
      end
    end
  end

  // Read select; an address with no matching channel yields zero.
  always_comb begin
    rd_lo_c = '0;
    rd_hi_c = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (bus.rd_addr == AW'(i)) begin
        rd_lo_c = cnt_q[i][BUS_WIDTH-1:0];
        rd_hi_c = cnt_q[i][WIDTH-1:BUS_WIDTH];
      end
    end
  end

  // Read response and shadow capture; data holds when no read is issued.
  always_comb begin
    rd_data_d = rd_data_q;
    shadow_d  = shadow_q;
    if (bus.rd_en) begin
      if (bus.rd_hi) begin
        rd_data_d = BUS_WIDTH'(shadow_q);
      end else begin
        rd_data_d = rd_lo_c;
        shadow_d  = rd_hi_c;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        cnt_q[i] <= PRESET;
      end
      ovf_q      <= '0;
      shadow_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      ovf_q      <= ovf_d;
      shadow_q   <= shadow_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= bus.rd_en;
    end
  end

  assign ovf          = ovf_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_counter_bank.sv
// Bench for counter_bank: a wrapping bank (PRESET 0) and a saturating bank
// (PRESET 3). Read responses are checked by scoreboard monitors.
module tb_counter_bank;
  localparam int unsigned W  = 64;
  localparam int unsigned CH = 4;
  localparam int unsigned BW = 32;
  localparam int unsigned AW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] inc, inhibit, ovf;
  logic [CH-1:0] inc_s, inhibit_s, ovf_s;

  always #5 clk = ~clk;

  counter_bank_if #(.BUS_WIDTH(BW), .AW(AW)) bus ();
  counter_bank_if #(.BUS_WIDTH(BW), .AW(AW)) bus_s ();

  counter_bank #(.WIDTH(W), .CHANNELS(CH), .BUS_WIDTH(BW), .SATURATE(1'b0),
                 .PRESET(64'h0), .AW(AW)) dut (
    .clk(clk), .reset(reset), .inc(inc), .inhibit(inhibit), .ovf(ovf), .bus(bus)
  );

  counter_bank #(.WIDTH(W), .CHANNELS(CH), .BUS_WIDTH(BW), .SATURATE(1'b1),
                 .PRESET(64'h3), .AW(AW)) dut_s (
    .clk(clk), .reset(reset), .inc(inc_s), .inhibit(inhibit_s), .ovf(ovf_s), .bus(bus_s)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [BW-1:0] exp0_q[$];
  logic [BW-1:0] exp1_q[$];

  // Scoreboard monitors: pop one expected word per rd_valid.
  always @(negedge clk) begin
    if (bus.rd_valid) begin
      n_cmp++;
      if (exp0_q.size() == 0) begin
        n_bad++;
        $display("FAIL rd0_unexpected: rd_valid with data %h, nothing expected", bus.rd_data);
      end else begin
        logic [BW-1:0] e;
        e = exp0_q.pop_front();
        if (bus.rd_data !== e) begin
          n_bad++;
          $display("FAIL rd0_data: got %h expected %h", bus.rd_data, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus_s.rd_valid) begin
      n_cmp++;
      if (exp1_q.size() == 0) begin
        n_bad++;
        $display("FAIL rd1_unexpected: rd_valid with data %h, nothing expected", bus_s.rd_data);
      end else begin
        logic [BW-1:0] e;
        e = exp1_q.pop_front();
        if (bus_s.rd_data !== e) begin
          n_bad++;
          $display("FAIL rd1_data: got %h expected %h", bus_s.rd_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] e);
    n_cmp++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, e);
    end
  endtask

  task automatic wr(input bit s, input int a, input bit hi, input logic [BW-1:0] d);
    if (!s) begin
      bus.wr_en = 1'b1; bus.wr_addr = AW'(a); bus.wr_hi = hi; bus.wr_data = d;
    end else begin
      bus_s.wr_en = 1'b1; bus_s.wr_addr = AW'(a); bus_s.wr_hi = hi; bus_s.wr_data = d;
    end
    tick();
    bus.wr_en = 1'b0;
    bus_s.wr_en = 1'b0;
  endtask

  task automatic rd(input bit s, input int a, input bit hi, input logic [BW-1:0] e);
    if (!s) begin
      bus.rd_en = 1'b1; bus.rd_addr = AW'(a); bus.rd_hi = hi;
      exp0_q.push_back(e);
    end else begin
      bus_s.rd_en = 1'b1; bus_s.rd_addr = AW'(a); bus_s.rd_hi = hi;
      exp1_q.push_back(e);
    end
    tick();
    bus.rd_en = 1'b0;
    bus_s.rd_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    inc = '0; inhibit = '0; inc_s = '0; inhibit_s = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_hi = 1'b0; bus.wr_data = '0;
    bus.rd_en = 1'b0; bus.rd_addr = '0; bus.rd_hi = 1'b0;
    bus_s.wr_en = 1'b0; bus_s.wr_addr = '0; bus_s.wr_hi = 1'b0; bus_s.wr_data = '0;
    bus_s.rd_en = 1'b0; bus_s.rd_addr = '0; bus_s.rd_hi = 1'b0;
    tick();
    tick();
    chk("reset_ovf", 64'(ovf), 64'h0);
    chk("reset_rd_valid", 64'(bus.rd_valid), 64'h0);
    chk("reset_rd_data", 64'(bus.rd_data), 64'h0);
    reset = 1'b0;

    // Saturating bank comes out of reset at PRESET = 3.
    rd(1'b1, 0, 1'b0, 32'h3);
    rd(1'b1, 0, 1'b1, 32'h0);

    // Five increments on ch0.
    inc[0] = 1'b1;
    repeat (5) tick();
    inc[0] = 1'b0;
    rd(1'b0, 0, 1'b0, 32'h5);
    chk("count5_ovf", 64'(ovf), 64'h0);
    tick();
    chk("rd_data_hold", 64'(bus.rd_data), 64'h5);

    // Carry from lo into hi on ch1.
    wr(1'b0, 1, 1'b0, 32'hFFFF_FFFF);
    wr(1'b0, 1, 1'b1, 32'h0);
    inc[1] = 1'b1;
    tick();
    inc[1] = 1'b0;
    rd(1'b0, 1, 1'b0, 32'h0);
    rd(1'b0, 1, 1'b1, 32'h1);

    // Coherent split read on ch2 while it keeps counting across the carry.
    wr(1'b0, 2, 1'b0, 32'hFFFF_FFFF);
    wr(1'b0, 2, 1'b1, 32'h0);
    inc[2] = 1'b1;
    rd(1'b0, 2, 1'b0, 32'hFFFF_FFFF);
    rd(1'b0, 2, 1'b1, 32'h0);
    inc[2] = 1'b0;
    rd(1'b0, 2, 1'b0, 32'h1);
    rd(1'b0, 2, 1'b1, 32'h1);

    // Wrap on ch3, then a write clears the flag.
    wr(1'b0, 3, 1'b0, 32'hFFFF_FFFF);
    wr(1'b0, 3, 1'b1, 32'hFFFF_FFFF);
    inc[3] = 1'b1;
    tick();
    inc[3] = 1'b0;
    chk("wrap_ovf", 64'(ovf), 64'h8);
    rd(1'b0, 3, 1'b0, 32'h0);
    rd(1'b0, 3, 1'b1, 32'h0);
    wr(1'b0, 3, 1'b0, 32'h7);
    chk("wrap_ovf_clear", 64'(ovf), 64'h0);
    rd(1'b0, 3, 1'b0, 32'h7);

    // Saturation on the second bank's ch3.
    wr(1'b1, 3, 1'b0, 32'hFFFF_FFFF);
    wr(1'b1, 3, 1'b1, 32'hFFFF_FFFF);
    inc_s[3] = 1'b1;
    tick();
    chk("sat_ovf", 64'(ovf_s), 64'h8);
    tick();
    inc_s[3] = 1'b0;
    chk("sat_ovf_sticky", 64'(ovf_s), 64'h8);
    rd(1'b1, 3, 1'b0, 32'hFFFF_FFFF);
    rd(1'b1, 3, 1'b1, 32'hFFFF_FFFF);
    wr(1'b1, 3, 1'b0, 32'h7);
    chk("sat_ovf_clear", 64'(ovf_s), 64'h0);
    rd(1'b1, 3, 1'b0, 32'h7);
    rd(1'b1, 3, 1'b1, 32'hFFFF_FFFF);

    // Write beats same-cycle increment on ch0; ch2 counts alongside.
    inc[0] = 1'b1;
    inc[2] = 1'b1;
    wr(1'b0, 0, 1'b0, 32'h10);
    inc[0] = 1'b0;
    inc[2] = 1'b0;
    rd(1'b0, 0, 1'b0, 32'h10);
    rd(1'b0, 0, 1'b1, 32'h0);
    rd(1'b0, 2, 1'b0, 32'h2);

    // Inhibited channel holds.
    inhibit[1] = 1'b1;
    inc[1] = 1'b1;
    repeat (10) tick();
    inc[1] = 1'b0;
    inhibit[1] = 1'b0;
    rd(1'b0, 1, 1'b0, 32'h0);
    rd(1'b0, 1, 1'b1, 32'h1);

    // Read and write of the same channel in one cycle: read sees old value.
    bus.wr_en = 1'b1; bus.wr_addr = 2'd0; bus.wr_hi = 1'b0; bus.wr_data = 32'h55;
    rd(1'b0, 0, 1'b0, 32'h10);
    bus.wr_en = 1'b0;
    rd(1'b0, 0, 1'b0, 32'h55);

    // Re-arm ch3 overflow, then reset with a read pending.
    wr(1'b0, 3, 1'b0, 32'hFFFF_FFFF);
    wr(1'b0, 3, 1'b1, 32'hFFFF_FFFF);
    inc[3] = 1'b1;
    tick();
    inc[3] = 1'b0;
    chk("rearm_ovf", 64'(ovf), 64'h8);
    repeat (2) tick();
    bus.rd_en = 1'b1; bus.rd_addr = 2'd0; bus.rd_hi = 1'b0;
    bus_s.rd_en = 1'b1; bus_s.rd_addr = 2'd3; bus_s.rd_hi = 1'b0;
    reset = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    bus_s.rd_en = 1'b0;
    reset = 1'b0;
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'h0);
    chk("rst_rd_data", 64'(bus.rd_data), 64'h0);
    chk("rst_ovf", 64'(ovf), 64'h0);
    tick();
    chk("rst_rd_valid_next", 64'(bus.rd_valid), 64'h0);
    for (int c = 0; c < int'(CH); c++) begin
      rd(1'b0, c, 1'b0, 32'h0);
      rd(1'b0, c, 1'b1, 32'h0);
    end
    rd(1'b1, 3, 1'b0, 32'h3);
    rd(1'b1, 3, 1'b1, 32'h0);

    // Drain the scoreboards with a bounded wait.
    begin
      int budget;
      budget = 20;
      while ((exp0_q.size() != 0 || exp1_q.size() != 0) && budget > 0) begin
        tick();
        budget--;
      end
      if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL drain_timeout: %0d and %0d responses missing, 0 required",
                 exp0_q.size(), exp1_q.size());
      end
    end
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/counter_bank.md
Name: counter_bank

Overview:
- Parametrised bank of CHANNELS independent up-counters, each WIDTH bits, with a narrow BUS_WIDTH access port.
- The port supports word-wise preload and coherent split reads, with a per-channel sticky overflow flag.
- Successor to the single-channel counter element.
- Used for mcycle/minstret-style and event counters on the rv32 multicycle core. Counts wider than the data bus are accessed as lo/hi halves.

Parameters:
- WIDTH, 64, counter width; legal range BUS_WIDTH < WIDTH <= 2*BUS_WIDTH.
- CHANNELS, 4, number of counters; >= 1.
- BUS_WIDTH, 32, read/write data width.
- SATURATE, 0, 0 = wrap to 0 on overflow, 1 = hold at all-ones.
- PRESET, 0, value loaded into every counter on reset.
- AW, $clog2(CHANNELS) (min 1), channel address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- inc  in  CHANNELS  per-channel increment request, sampled each cycle.
- inhibit  in  CHANNELS  per-channel count gate; 1 = inc ignored.
- wr_en  in  1  write strobe.
- wr_addr  in  AW  channel written.
- wr_hi  in  1  0 = write bits [BUS_WIDTH-1:0], 1 = write bits [WIDTH-1:BUS_WIDTH].
- wr_data  in  BUS_WIDTH  write data; excess hi bits ignored.
- rd_en  in  1  read strobe.
- rd_addr  in  AW  channel read.
- rd_hi  in  1  0 = lo half (captures hi shadow), 1 = hi half from shadow.
- rd_data  out  BUS_WIDTH  registered read data.
- rd_valid  out  1  pulses 1 cycle after rd_en.
- ovf  out  CHANNELS  sticky overflow flags.

Behaviour:
- Reset, while asserted, every cycle:
  - All counters = PRESET.
  - ovf = 0, rd_data = 0, rd_valid = 0, shadow = 0.
  - Reset overrides inc, wr_en and rd_en. Reset mid-operation discards any pending read; rd_valid is 0 the cycle after.
- Counting, per channel i, per cycle:
  - Counts when inc[i] & ~inhibit[i], unless that channel is written this cycle.
  - cnt[i] <= cnt[i] + 1, mod 2^WIDTH.
- Overflow, when counting at all-ones:
  - SATURATE=0: wraps to 0 and sets ovf[i].
  - SATURATE=1: stays all-ones and sets ovf[i]. Further incs keep it all-ones; ovf stays 1.
- Write, when wr_en:
  - Only the selected half of cnt[wr_addr] is replaced; the other half is unchanged.
  - The write clears ovf[wr_addr].
  - Write takes priority over a same-cycle increment of that channel; the increment is lost.
  - Other channels count normally.
  - wr_addr >= CHANNELS: no effect.
- Read, 1-cycle latency:
  - rd_en with rd_hi=0: rd_data <= cnt[rd_addr][BUS_WIDTH-1:0] and, in the same edge, shadow <= cnt[rd_addr][WIDTH-1:BUS_WIDTH], zero-extended.
  - rd_en with rd_hi=1: rd_data <= shadow. rd_addr is ignored.
  - The result is a coherent 64-bit snapshot from the lo read, even across a lo→hi carry between the two reads.
  - rd_valid <= rd_en. rd_data holds its value when rd_en=0.
  - Read values are pre-update values (read-before-increment/write in the same cycle).
  - rd_addr >= CHANNELS: returns 0 and shadow <= 0.
- Simultaneous read and write of the same channel in one cycle: the read returns the old value; the write takes effect.
- ovf is a plain register bit per channel; only reset or a write to that channel clears it.
- No combinational path from inputs to outputs.

Test Plan:
- Reset then inc[0]=1 for 5 cycles, then rd_en lo ch0 → rd_valid next cycle, rd_data=5; ovf=0.
- Write ch1 lo=0xFFFF_FFFF and hi=0, inc[1] for 1 cycle, then read lo then hi → lo=0, hi=1.
- Read lo ch2 at 0x0000_0000_FFFF_FFFF, inc[2] continuously, read hi next cycle → hi=0 (shadow coherent), while the counter itself is now 0x1_0000_0001.
- Preload ch3 to all-ones, inc[3] 1 cycle:
  - SATURATE=0 → counter=0, ovf[3]=1.
  - SATURATE=1 → counter stays all-ones, ovf[3]=1.
  - Then write ch3 lo=7 → ovf[3]=0, counter lo=7.
- wr_en ch0 lo=0x10 with inc[0]=1 in the same cycle → counter=0x10 (inc dropped). inhibit[1]=1 with inc[1]=1 for 10 cycles → ch1 unchanged.
- Assert reset for 1 cycle while rd_en is pending and counters are nonzero → all counters=PRESET, rd_valid=0, rd_data=0, ovf=0 next cycle.
